// File: rtl/adc_capture_buf.sv
// Triggered ADC capture into a circular buffer with pre-trigger window,
// followed by chronological readout over a two-cycle-latency read handshake.
module adc_capture_buf #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 256
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              samp_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              force_trig,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W:0]   REQ_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   REQ_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_READY
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_samp_d;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_ok;
    logic              r_wr_pend;
    logic              r_force_pend;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W:0]   r_req_cnt;
    logic              r_v1;
    logic              r_last1;
    logic [DATA_W-1:0] r_ram_q;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_tick;
    logic w_busy;
    logic w_wr;
    logic w_rise;
    logic w_fall;
    logic w_cond;
    logic w_trig;
    logic w_rd_acc;

    assign w_tick   = samp_clk & ~r_samp_d;
    assign w_busy   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    // A tick coinciding with arm is dropped; capture begins on the following tick.
    assign w_wr     = r_wr_pend & w_busy & ~arm;
    assign w_rise   = (r_prev < trig_level) && (r_cur >= trig_level);
    assign w_fall   = (r_prev > trig_level) && (r_cur <= trig_level);
    assign w_cond   = r_prev_ok & (trig_slope ? w_fall : w_rise);
    assign w_trig   = (r_state == S_WAIT) & w_wr & (w_cond | force_trig | r_force_pend);
    assign w_rd_acc = (r_state == S_READY) & rd_req & ~arm & (r_req_cnt < REQ_MAX);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = w_busy;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_PRE: begin
                if (w_wr && (r_pre_cnt == PRE_LAST)) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_trig) w_state_nxt = (PRE_TRIG == DEPTH - 1) ? S_READY : S_POST;
            end
            S_POST: begin
                if (w_wr && (r_post_cnt == POST_LAST)) w_state_nxt = S_READY;
            end
            S_READY: begin
                done = 1'b1;
                if (rd_valid && rd_last) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (arm) w_state_nxt = S_PRE;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp_d     <= 1'b0;
            r_cur        <= '0;
            r_prev       <= '0;
            r_prev_ok    <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_force_pend <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_req_cnt    <= '0;
            r_v1         <= 1'b0;
            r_last1      <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
        end else begin
            r_samp_d <= samp_clk;
            if (w_tick) begin
                r_cur  <= adc_data;
                r_prev <= r_cur;
            end
            if (arm) begin
                r_wr_pend    <= 1'b0;
                r_wr_ptr     <= '0;
                r_pre_cnt    <= '0;
                r_post_cnt   <= '0;
                r_prev_ok    <= 1'b0;
                r_force_pend <= 1'b0;
                r_req_cnt    <= '0;
                r_v1         <= 1'b0;
                r_last1      <= 1'b0;
                rd_valid     <= 1'b0;
                rd_last      <= 1'b0;
            end else begin
                r_wr_pend <= w_tick & w_busy;
                if (w_wr) begin
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                    r_prev_ok <= 1'b1;
                end
                if (w_wr && (r_state == S_PRE))  r_pre_cnt  <= r_pre_cnt + 1'b1;
                if (w_wr && (r_state == S_POST)) r_post_cnt <= r_post_cnt + 1'b1;
                if ((r_state == S_WAIT) && force_trig) r_force_pend <= 1'b1;
                // Readout start is fixed at trigger time: trigger address minus the pre-trigger window.
                if (w_trig) begin
                    r_post_cnt   <= ADDR_W'(1);
                    r_force_pend <= 1'b0;
                    r_rd_ptr     <= r_wr_ptr - PRE_OFS;
                end
                r_v1    <= w_rd_acc;
                r_last1 <= w_rd_acc && (r_req_cnt == REQ_LAST);
                if (w_rd_acc) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_req_cnt <= r_req_cnt + 1'b1;
                end
                rd_valid <= r_v1;
                rd_last  <= r_v1 & r_last1;
                if (r_v1) rd_data <= r_ram_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_cur;
        if (w_rd_acc) r_ram_q <= r_mem[r_rd_ptr];
    end

endmodule

// File: tb/tb_adc_capture_buf.sv
// Randomized bench for adc_capture_buf: a sample-list model predicts trigger
// position, frame completion and the chronological readout frame.
module tb_adc_capture_buf;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 10;
    localparam int PRE_TRIG = 256;
    localparam int DEPTH    = 1024;
    localparam int POST     = DEPTH - PRE_TRIG;

    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic              samp_clk;
    logic [DATA_W-1:0] adc_data;
    logic              arm;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic              force_trig;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    int smp[$];
    int trig_k   = -1;
    int force_at = -1;
    bit armed    = 1'b0;
    int got[DEPTH];

    always #5 sys_clk = ~sys_clk;

    adc_capture_buf #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .PRE_TRIG(PRE_TRIG)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .samp_clk  (samp_clk),
        .adc_data  (adc_data),
        .arm       (arm),
        .trig_level(trig_level),
        .trig_slope(trig_slope),
        .force_trig(force_trig),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic void model_arm();
        smp.delete();
        trig_k   = -1;
        force_at = -1;
        armed    = 1'b1;
    endfunction

    function automatic void model_push(input int v);
        int i;
        bit hit;
        smp.push_back(v);
        i = smp.size() - 1;
        if (trig_k < 0 && i >= PRE_TRIG) begin
            if (trig_slope == 1'b0)
                hit = (smp[i-1] < int'(trig_level)) && (v >= int'(trig_level));
            else
                hit = (smp[i-1] > int'(trig_level)) && (v <= int'(trig_level));
            if (hit || i == force_at) trig_k = i;
        end
    endfunction

    function automatic bit exp_done();
        return armed && trig_k >= 0 && smp.size() >= trig_k + POST;
    endfunction

    function automatic bit exp_busy();
        return armed && !(trig_k >= 0 && smp.size() >= trig_k + POST);
    endfunction

    task automatic do_sample(input int v, input bit with_arm);
        @(negedge sys_clk);
        samp_clk = 1'b1;
        adc_data = v[DATA_W-1:0];
        arm      = with_arm;
        rd_req   = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        arm    = 1'b0;
        rd_req = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        samp_clk = 1'b0;
        rd_req   = 1'b0;
        @(negedge sys_clk);
        if (with_arm) model_arm();
        else if (armed && !exp_done()) model_push(v);
        n_checks++;
        if (done !== exp_done()) begin
            n_fail++;
            $display("FAIL done after sample %0d: got %b expected %b", smp.size(), done, exp_done());
        end
        n_checks++;
        if (busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL busy after sample %0d: got %b expected %b", smp.size(), busy, exp_busy());
        end
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_valid during capture: got %b expected 0", rd_valid);
        end
    endtask

    task automatic pulse_arm();
        @(negedge sys_clk);
        arm = 1'b1;
        @(negedge sys_clk);
        arm = 1'b0;
        model_arm();
    endtask

    task automatic pulse_force();
        @(negedge sys_clk);
        force_trig = 1'b1;
        @(negedge sys_clk);
        force_trig = 1'b0;
        if (armed && trig_k < 0 && smp.size() >= PRE_TRIG) force_at = smp.size();
    endtask

    task automatic run_to_done_random();
        for (int n = 0; n < 4000 && !exp_done(); n++) do_sample(int'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic run_to_done_const(input int v);
        for (int n = 0; n < 4000 && !exp_done(); n++) do_sample(v, 1'b0);
    endtask

    task automatic do_readout(input int n_cyc, input int gap_pct, input int abort_at, output int n_got);
        int hist[4096];
        int issued;
        int idx;
        int exp_v;
        bit aborted;
        issued  = 0;
        n_got   = 0;
        aborted = 1'b0;
        for (int c = 0; c < n_cyc + 3; c++) begin
            @(negedge sys_clk);
            if (c >= 2) begin
                idx = hist[c-2];
                n_checks++;
                if (rd_valid !== (idx >= 0)) begin
                    n_fail++;
                    $display("FAIL rd_valid cycle %0d: got %b expected %b", c, rd_valid, idx >= 0);
                end
                if (idx >= 0) begin
                    exp_v = smp[trig_k - PRE_TRIG + idx];
                    n_checks++;
                    if (rd_data !== exp_v[DATA_W-1:0]) begin
                        n_fail++;
                        $display("FAIL rd_data index %0d: got %0d expected %0d", idx, rd_data, exp_v);
                    end
                    n_checks++;
                    if (rd_last !== (idx == DEPTH - 1)) begin
                        n_fail++;
                        $display("FAIL rd_last index %0d: got %b expected %b", idx, rd_last, idx == DEPTH - 1);
                    end
                    got[idx] = int'(rd_data);
                    n_got++;
                end
            end
            arm = (c == abort_at);
            if (c == abort_at) begin
                aborted = 1'b1;
                if (c >= 1) hist[c-1] = -1;
                model_arm();
            end
            rd_req = (c < n_cyc) && !aborted && (int'($urandom_range(0, 99)) >= gap_pct);
            if (rd_req && issued < DEPTH) begin
                hist[c] = issued;
                issued++;
            end else begin
                hist[c] = -1;
            end
        end
        arm    = 1'b0;
        rd_req = 1'b0;
        if (!aborted && issued == DEPTH) armed = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (done !== exp_done()) begin
            n_fail++;
            $display("FAIL done after readout: got %b expected %b", done, exp_done());
        end
        n_checks++;
        if (busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL busy after readout: got %b expected %b", busy, exp_busy());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        samp_clk = 1'b0; adc_data = '0; arm = 1'b0; trig_level = '0;
        trig_slope = 1'b0; force_trig = 1'b0; rd_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({rd_data, rd_valid, rd_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 0", {rd_data, rd_valid, rd_last, busy, done});
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: got busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_ramp_rising();
        int start;
        int ng;
        start      = int'($urandom_range(0, 255));
        trig_slope = 1'b0;
        trig_level = 8'd128;
        pulse_arm();
        for (int n = 0; n < 4000 && !exp_done(); n++) do_sample((start + n) % 256, 1'b0);
        do_readout(DEPTH + 1, 0, -1, ng);
        n_checks++;
        if (ng !== DEPTH) begin
            n_fail++;
            $display("FAIL ramp response count: got %0d expected %0d", ng, DEPTH);
        end
        n_checks++;
        if (got[PRE_TRIG] !== 128 || got[PRE_TRIG-1] !== 127) begin
            n_fail++;
            $display("FAIL ramp trigger sample: got %0d,%0d expected 127,128", got[PRE_TRIG-1], got[PRE_TRIG]);
        end
    endtask

    task automatic test_force_const();
        int ng;
        int bad;
        trig_slope = 1'b0;
        trig_level = 8'd100;
        pulse_arm();
        for (int n = 0; n < 100; n++) do_sample(50, 1'b0);
        pulse_force();
        for (int n = 0; n < 200; n++) do_sample(50, 1'b0);
        pulse_force();
        run_to_done_const(50);
        do_readout(1700, 30, -1, ng);
        bad = 0;
        for (int i = 0; i < ng; i++) if (got[i] != 50) bad++;
        n_checks++;
        if (bad !== 0 || ng !== DEPTH) begin
            n_fail++;
            $display("FAIL force frame: got %0d responses %0d non-50 expected %0d responses 0", ng, bad, DEPTH);
        end
    endtask

    task automatic test_slopes();
        int ng;
        trig_slope = 1'b1;
        trig_level = 8'd100;
        pulse_arm();
        for (int n = 0; n < 306; n++) do_sample(100, 1'b0);
        do_sample(101, 1'b0);
        do_sample(100, 1'b0);
        run_to_done_const(100);
        do_readout(DEPTH + 1, 0, -1, ng);
        trig_slope = 1'b0;
        pulse_arm();
        for (int n = 0; n < 306; n++) do_sample(100, 1'b0);
        do_sample(101, 1'b0);
        do_sample(100, 1'b0);
        for (int n = 0; n < 20; n++) do_sample(100, 1'b0);
        pulse_force();
        run_to_done_const(100);
    endtask

    task automatic test_pre_ignore();
        int ng;
        trig_slope = 1'b0;
        trig_level = 8'd128;
        pulse_arm();
        for (int n = 0; n < 10; n++) do_sample(0, 1'b0);
        for (int n = 10; n < 320; n++) do_sample(200, 1'b0);
        for (int n = 0; n < 5; n++) do_sample(0, 1'b0);
        pulse_force();
        do_sample(200, 1'b0);
        run_to_done_random();
        do_readout(1500, 25, -1, ng);
    endtask

    task automatic test_rearm_post();
        int ng;
        trig_slope = 1'($urandom_range(0, 1));
        trig_level = 8'($urandom_range(60, 190));
        pulse_arm();
        for (int n = 0; n < 4000 && !(trig_k >= 0 && smp.size() >= trig_k + 300); n++)
            do_sample(int'($urandom_range(0, 255)), 1'b0);
        do_sample(int'($urandom_range(0, 255)), 1'b1);
        run_to_done_random();
        do_readout(DEPTH + 1, 0, -1, ng);
    endtask

    task automatic test_reset_mid_and_ready_abort();
        int ng;
        trig_slope = 1'b0;
        trig_level = 8'd255;
        pulse_arm();
        for (int n = 0; n < 300; n++) do_sample(10, 1'b0);
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_data, rd_valid, rd_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL async reset outputs: got %h expected 0", {rd_data, rd_valid, rd_last, busy, done});
        end
        armed = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        trig_level = 8'd128;
        pulse_arm();
        run_to_done_random();
        do_readout(DEPTH, 0, 500, ng);
        run_to_done_random();
        do_readout(DEPTH + 1, 0, -1, ng);
    endtask

    initial begin
        test_reset();
        test_ramp_rising();
        test_force_const();
        test_slopes();
        test_pre_ignore();
        test_rearm_post();
        test_reset_mid_and_ready_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
